// File: rtl/dispensador_troco.sv
// Coin change dispenser: pays out TROCO (10-cent units) using 50/20/10 coins,
// largest-first with stock awareness, handshaking each coin with the ejector
// through ACK and falling into a sticky FAULT on timeout or impossible change.
module dispensador_troco #(
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned STK_INIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] troco_i,
    input  logic       repor_i,
    input  logic       ack_i,
    output logic       ej50_o,
    output logic       ej20_o,
    output logic       ej10_o,
    output logic       busy_o,
    output logic       fim_o,
    output logic       erro_o,
    output logic       falha_o,
    output logic       vazio_o
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_PULSE    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_50   = 2'd1,
        COIN_20   = 2'd2,
        COIN_10   = 2'd3
    } coin_t;

    localparam logic [3:0] STK_RST   = 4'(STK_INIT);
    localparam logic [4:0] TMO       = 5'(TIMEOUT);
    localparam logic       VAZIO_RST = (STK_INIT == 0) ? 1'b1 : 1'b0;

    // Value of a coin in 10-cent units.
    function automatic logic [3:0] coin_value(input coin_t c);
        logic [3:0] v;
        case (c)
            COIN_50: v = 4'd5;
            COIN_20: v = 4'd2;
            COIN_10: v = 4'd1;
            default: v = 4'd0;
        endcase
        return v;
    endfunction

    // Decrement that saturates at zero so a stock can never wrap.
    function automatic logic [3:0] sat_dec(input logic [3:0] x);
        return (x != 4'd0) ? (x - 4'd1) : 4'd0;
    endfunction

    state_t     state_q, state_d;
    coin_t      coin_q, coin_d;
    logic [3:0] rem_q, rem_d;
    logic [3:0] tmr_q, tmr_d;
    logic [3:0] stk50_q, stk50_d;
    logic [3:0] stk20_q, stk20_d;
    logic [3:0] stk10_q, stk10_d;
    logic       ej50_q, ej50_d;
    logic       ej20_q, ej20_d;
    logic       ej10_q, ej10_d;
    logic       busy_q, busy_d;
    logic       fim_q, fim_d;
    logic       erro_q, erro_d;
    logic       falha_q, falha_d;
    logic       vazio_q, vazio_d;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        coin_d  = coin_q;
        rem_d   = rem_q;
        tmr_d   = tmr_q;
        stk50_d = stk50_q;
        stk20_d = stk20_q;
        stk10_d = stk10_q;
        ej50_d  = 1'b0;
        ej20_d  = 1'b0;
        ej10_d  = 1'b0;
        fim_d   = 1'b0;
        erro_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    // LOAD has priority over REPOR when both arrive together.
                    if (troco_i <= 4'd10) begin
                        rem_d   = troco_i;
                        state_d = ST_SELECT;
                    end else begin
                        erro_d = 1'b1;
                    end
                end else if (repor_i) begin
                    stk50_d = 4'd15;
                    stk20_d = 4'd15;
                    stk10_d = 4'd15;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                coin_d = COIN_NONE;
                if (rem_q == 4'd0) begin
                    state_d = ST_DONE;
                end else if ((rem_q >= 4'd5) && (stk50_q != 4'd0)) begin
                    coin_d  = COIN_50;
                    state_d = ST_PULSE;
                end else if ((rem_q >= 4'd2) && (stk20_q != 4'd0)) begin
                    coin_d  = COIN_20;
                    state_d = ST_PULSE;
                end else if (stk10_q != 4'd0) begin
                    coin_d  = COIN_10;
                    state_d = ST_PULSE;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            ST_PULSE: begin
                tmr_d   = 4'd0;
                state_d = ST_WAIT_ACK;
                rem_d   = (rem_q >= coin_value(coin_q)) ? (rem_q - coin_value(coin_q)) : 4'd0;
                case (coin_q)
                    COIN_50: begin
                        ej50_d  = 1'b1;
                        stk50_d = sat_dec(stk50_q);
                    end
                    COIN_20: begin
                        ej20_d  = 1'b1;
                        stk20_d = sat_dec(stk20_q);
                    end
                    COIN_10: begin
                        ej10_d  = 1'b1;
                        stk10_d = sat_dec(stk10_q);
                    end
                    default: begin
                        // No coin latched: treat as an internal inconsistency.
                        state_d = ST_FAULT;
                    end
                endcase
            end
            ST_WAIT_ACK: begin
                if (ack_i) begin
                    state_d = ST_SELECT;
                end else begin
                    tmr_d = (tmr_q != 4'hF) ? (tmr_q + 4'd1) : tmr_q;
                    if (({1'b0, tmr_q} + 5'd1) >= TMO) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_WAIT_ACK;
                    end
                end
            end
            ST_DONE: begin
                fim_d   = 1'b1;
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        falha_d = (state_d == ST_FAULT);
        vazio_d = (stk50_d == 4'd0) || (stk20_d == 4'd0) || (stk10_d == 4'd0);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            coin_q  <= COIN_NONE;
            rem_q   <= 4'd0;
            tmr_q   <= 4'd0;
            stk50_q <= STK_RST;
            stk20_q <= STK_RST;
            stk10_q <= STK_RST;
            ej50_q  <= 1'b0;
            ej20_q  <= 1'b0;
            ej10_q  <= 1'b0;
            busy_q  <= 1'b0;
            fim_q   <= 1'b0;
            erro_q  <= 1'b0;
            falha_q <= 1'b0;
            vazio_q <= VAZIO_RST;
        end else begin
            state_q <= state_d;
            coin_q  <= coin_d;
            rem_q   <= rem_d;
            tmr_q   <= tmr_d;
            stk50_q <= stk50_d;
            stk20_q <= stk20_d;
            stk10_q <= stk10_d;
            ej50_q  <= ej50_d;
            ej20_q  <= ej20_d;
            ej10_q  <= ej10_d;
            busy_q  <= busy_d;
            fim_q   <= fim_d;
            erro_q  <= erro_d;
            falha_q <= falha_d;
            vazio_q <= vazio_d;
        end
    end

    assign ej50_o  = ej50_q;
    assign ej20_o  = ej20_q;
    assign ej10_o  = ej10_q;
    assign busy_o  = busy_q;
    assign fim_o   = fim_q;
    assign erro_o  = erro_q;
    assign falha_o = falha_q;
    assign vazio_o = vazio_q;

endmodule

// File: tb/tb_dispensador_troco.sv
// Self-checking bench for dispensador_troco: directed table, hand-written
// corner sequences, then randomized requests against a transaction-level model.
module tb_dispensador_troco;

    localparam int TIMEOUT = 15;

    logic       clk;
    logic       rst;
    logic       load_i;
    logic [3:0] troco_i;
    logic       repor_i;
    logic       ack_i;
    logic       ej50_o, ej20_o, ej10_o;
    logic       busy_o, fim_o, erro_o, falha_o, vazio_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: coin stocks and the coin sequence expected next.
    int m50, m20, m10;
    int exp_coins[$];

    dispensador_troco #(.TIMEOUT(TIMEOUT), .STK_INIT(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_i),
        .troco_i (troco_i),
        .repor_i (repor_i),
        .ack_i   (ack_i),
        .ej50_o  (ej50_o),
        .ej20_o  (ej20_o),
        .ej10_o  (ej10_o),
        .busy_o  (busy_o),
        .fim_o   (fim_o),
        .erro_o  (erro_o),
        .falha_o (falha_o),
        .vazio_o (vazio_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance clock cycles until the selected event is seen at a falling edge.
    // which: 0 = any eject, 1 = FIM, 2 = FALHA. cyc = -1 on timeout.
    task automatic wait_evt(input int which, input int maxc, output int cyc);
        logic hit;
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc <= maxc) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            case (which)
                0:       hit = ej50_o | ej20_o | ej10_o;
                1:       hit = fim_o;
                2:       hit = falha_o;
                default: hit = 1'b0;
            endcase
        end
        if (!hit) begin
            $display("FAIL wait_evt%0d: no event within %0d cycles", which, maxc);
            cyc = -1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ack_i = 1'b0; repor_i = 1'b0;
        load_i = 1'b1; troco_i = 4'd3;
        #1;
        chk("reset_outputs_async", {ej50_o, ej20_o, ej10_o, busy_o, fim_o, erro_o, falha_o, vazio_o}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_held", {ej50_o, ej20_o, ej10_o, busy_o, fim_o, erro_o, falha_o, vazio_o}, 0);
        load_i = 1'b0; troco_i = 4'd0;
        rst = 1'b0;
        m50 = 8; m20 = 8; m10 = 8;
    endtask

    task automatic do_repor();
        repor_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        repor_i = 1'b0;
        chk("repor_busy", busy_o, 0);
        chk("repor_vazio", vazio_o, 0);
        m50 = 15; m20 = 15; m10 = 15;
    endtask

    // One full request starting at a falling edge in IDLE. Coins come from exp_coins.
    task automatic run_txn(input int troco, input int dly, input bit want_erro,
                           input bit want_flt, input int exp_rem);
        int cyc;
        int got;
        int d;
        load_i  = 1'b1;
        troco_i = troco[3:0];
        @(posedge clk);
        @(negedge clk);
        load_i = 1'b0;
        if (want_erro) begin
            chk("erro_pulse", erro_o, 1);
            chk("erro_busy", busy_o, 0);
            @(posedge clk);
            @(negedge clk);
            chk("erro_width", erro_o, 0);
            chk("erro_no_ej", {ej50_o, ej20_o, ej10_o, busy_o}, 0);
            return;
        end
        chk("busy_after_load", busy_o, 1);
        foreach (exp_coins[k]) begin
            wait_evt(0, 8, cyc);
            chk("ej_latency", cyc, 2);
            got = ej50_o ? 5 : (ej20_o ? 2 : (ej10_o ? 1 : 0));
            chk("ej_coin", got, exp_coins[k]);
            chk("ej_onehot", 32'(ej50_o) + 32'(ej20_o) + 32'(ej10_o), 1);
            chk("busy_pulse", busy_o, 1);
            d = (dly < 0) ? int'($urandom_range(0, TIMEOUT - 2)) : dly;
            repeat (d) begin
                @(posedge clk);
                @(negedge clk);
            end
            ack_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ack_i = 1'b0;
            chk("ej_width", {ej50_o, ej20_o, ej10_o}, 0);
        end
        if (want_flt) begin
            wait_evt(2, 4, cyc);
            chk("fault_latency", cyc, 1);
            chk("fault_busy", busy_o, 1);
            chk("fault_rem", dut.rem_q, exp_rem);
            load_i = 1'b1; troco_i = 4'd12; repor_i = 1'b1; ack_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
            load_i = 1'b0; repor_i = 1'b0; ack_i = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("fault_sticky", {falha_o, busy_o, erro_o, fim_o, ej50_o, ej20_o, ej10_o}, 7'b1100000);
        end else begin
            wait_evt(1, 6, cyc);
            chk("fim_latency", cyc, 2);
            chk("fim_idle_busy", busy_o, 0);
            @(posedge clk);
            @(negedge clk);
            chk("fim_width", fim_o, 0);
        end
    endtask

    // Largest-first change with stock limits, expressed as coin counts.
    task automatic model_plan(input int troco, output bit flt, output int rem);
        int n50, n20, n10;
        rem = troco;
        n50 = (rem / 5 < m50) ? rem / 5 : m50;  rem -= 5 * n50;
        n20 = (rem / 2 < m20) ? rem / 2 : m20;  rem -= 2 * n20;
        n10 = (rem < m10) ? rem : m10;          rem -= n10;
        flt = (rem > 0);
        exp_coins.delete();
        repeat (n50) exp_coins.push_back(5);
        repeat (n20) exp_coins.push_back(2);
        repeat (n10) exp_coins.push_back(1);
    endtask

    task automatic model_take();
        foreach (exp_coins[k]) begin
            if (exp_coins[k] == 5) m50--;
            else if (exp_coins[k] == 2) m20--;
            else m10--;
        end
    endtask

    typedef struct {
        bit         rst_b;
        bit         repor_b;
        int         troco;
        int         dly;
        int         ncoin;
        logic [11:0] seq;   // coin values, first coin in the low nibble
        bit         flt;
        bit         erro;
        bit         vaz;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int cyc;
        int sum;
        int cnt;
        int r;
        int troco;
        int rem;
        bit flt;
        logic [11:0] sq;

        rst = 1'b1; load_i = 1'b0; troco_i = 4'd0; repor_i = 1'b0; ack_i = 1'b0;
        m50 = 8; m20 = 8; m10 = 8;

        tbl[0]  = '{1'b1, 1'b0, 10, 3, 2, 12'h055, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0,  9, 3, 3, 12'h225, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0,  4, 1, 2, 12'h022, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0,  4, 0, 2, 12'h022, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0,  4, 2, 2, 12'h022, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0,  7, 1, 3, 12'h115, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 15, 0, 0, 12'h000, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b1,  0, 0, 0, 12'h000, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0,  3, 0, 2, 12'h012, 1'b0, 1'b0, 1'b0};
        for (int i = 9; i < 15; i++)
            tbl[i] = '{1'b0, 1'b0, 3, 1, 2, 12'h012, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0,  1, 2, 1, 12'h001, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b0,  3, 0, 1, 12'h002, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rst_b) do_reset();
            @(negedge clk);
            if (tbl[i].repor_b) do_repor();
            exp_coins.delete();
            sum = 0;
            sq = tbl[i].seq;
            for (int k = 0; k < tbl[i].ncoin; k++) begin
                exp_coins.push_back(int'(sq[3:0]));
                sum += int'(sq[3:0]);
                sq = sq >> 4;
            end
            run_txn(tbl[i].troco, tbl[i].dly, tbl[i].erro, tbl[i].flt, tbl[i].troco - sum);
            model_take();
            chk("tbl_vazio", vazio_o, tbl[i].vaz);
            if (i == 0) chk("tbl_stk50_after_10", dut.stk50_q, 6);
            if (i == 1) chk("tbl_stk20_stk10_after_9", {dut.stk20_q, dut.stk10_q}, {4'd6, 4'd8});
        end

        // ACK never arrives: FALHA rises exactly TIMEOUT cycles after the pulse edge.
        do_reset();
        @(negedge clk);
        load_i = 1'b1; troco_i = 4'd10;
        @(posedge clk);
        @(negedge clk);
        load_i = 1'b0;
        wait_evt(0, 8, cyc);
        chk("to_first_ej", cyc, 2);
        wait_evt(2, TIMEOUT + 4, cyc);
        chk("timeout_cycles", cyc, TIMEOUT);
        chk("timeout_busy", busy_o, 1);

        // Reset mid WAIT_ACK, then an out-of-range LOAD right on the first edge.
        do_reset();
        @(negedge clk);
        load_i = 1'b1; troco_i = 4'd10;
        @(posedge clk);
        @(negedge clk);
        load_i = 1'b0;
        wait_evt(0, 8, cyc);
        @(posedge clk);
        @(negedge clk);
        chk("wait_ack_busy", busy_o, 1);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {ej50_o, ej20_o, ej10_o, busy_o, fim_o, erro_o, falha_o}, 0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_stocks", {dut.stk50_q, dut.stk20_q, dut.stk10_q, dut.rem_q}, {4'd8, 4'd8, 4'd8, 4'd0});
        chk("midrst_vazio", vazio_o, 0);
        rst = 1'b0;
        load_i = 1'b1; troco_i = 4'd12;
        @(posedge clk);
        @(negedge clk);
        load_i = 1'b0;
        chk("first_edge_erro", erro_o, 1);
        chk("first_edge_busy", busy_o, 0);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            cnt += int'(ej50_o | ej20_o | ej10_o | busy_o | erro_o | fim_o);
        end
        chk("erro_only_activity", cnt, 0);

        // LOAD and REPOR together: LOAD wins, stocks keep their values.
        do_reset();
        @(negedge clk);
        exp_coins.delete();
        exp_coins.push_back(1);
        run_txn(1, 0, 1'b0, 1'b0, 0);
        load_i = 1'b1; troco_i = 4'd0; repor_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_i = 1'b0; repor_i = 1'b0;
        wait_evt(1, 6, cyc);
        chk("troco0_fim_latency", cyc, 2);
        chk("load_beats_repor", {dut.stk50_q, dut.stk20_q, dut.stk10_q}, {4'd8, 4'd8, 4'd7});

        // Randomized requests against the model.
        do_reset();
        @(negedge clk);
        for (int t = 0; t < 60; t++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                do_repor();
            end else if (r == 1) begin
                troco = int'($urandom_range(11, 15));
                exp_coins.delete();
                run_txn(troco, -1, 1'b1, 1'b0, 0);
            end else begin
                troco = int'($urandom_range(0, 10));
                model_plan(troco, flt, rem);
                run_txn(troco, -1, 1'b0, flt, rem);
                model_take();
                chk("rnd_vazio", vazio_o, (m50 == 0 || m20 == 0 || m10 == 0) ? 1 : 0);
                if (flt) begin
                    do_reset();
                    @(negedge clk);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dispensador_troco.md
DISPENSADOR_TROCO -- requirements
Module: dispensador_troco

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles spent waiting for ACK per coin.
REQ-002 SHALL have parameter STK_INIT, default 8, meaning the reset value of each coin stock counter.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port LOAD, input, 1, a change request strobe, sampled in IDLE only.
REQ-006 SHALL have port TROCO, input, 4, the change amount in 10-cent units (valid range 0..10).
REQ-007 SHALL have port REPOR, input, 1, the refill command, honoured in IDLE only.
REQ-008 SHALL have port ACK, input, 1, the ejector acknowledge that the last coin has left.
REQ-009 SHALL have ports EJ50, EJ20 and EJ10, output, 1 each, one-cycle eject pulses to the coin ejector.
REQ-010 SHALL have port BUSY, output, 1, high while a request is in progress.
REQ-011 SHALL have port FIM, output, 1, a one-cycle pulse on successful completion.
REQ-012 SHALL have port ERRO, output, 1, a one-cycle pulse on a rejected request.
REQ-013 SHALL have port FALHA, output, 1, a sticky fault flag.
REQ-014 SHALL have port VAZIO, output, 1, high when any stock counter is 0.

Function
REQ-015 SHALL implement states IDLE, SELECT, PULSE, WAIT_ACK, DONE and FAULT; all outputs SHALL be registered or decoded from state only.
REQ-016 SHALL keep 4-bit registers REM, STK50, STK20 and STK10, plus a 4-bit timeout counter TMR.
REQ-017 SHALL, in IDLE with LOAD=1 and TROCO<=10: latch REM=TROCO and go to SELECT.
REQ-018 SHALL, in IDLE with LOAD=1 and TROCO>10: pulse ERRO for 1 cycle, leave REM unchanged, and stay in IDLE.
REQ-019 SHALL, in IDLE with LOAD=0 and REPOR=1: set STK50, STK20 and STK10 to 15; when LOAD=1 and REPOR=1 arrive together, LOAD wins and REPOR is ignored.
REQ-020 SHALL, in SELECT with REM=0: go to DONE.
REQ-021 SHALL, in SELECT with REM>0: pick the largest coin in priority order 50 (5 units), 20 (2 units), 10 (1 unit) whose value is <=REM and whose stock is >0, then go to PULSE; if no coin qualifies, go to FAULT.
REQ-022 SHALL, in PULSE: assert exactly one of EJ50/EJ20/EJ10 (the selected coin) for exactly 1 cycle, subtract the coin value from REM, decrement that stock, clear TMR, and go to WAIT_ACK.
REQ-023 SHALL, in WAIT_ACK: go to SELECT when ACK=1; otherwise increment TMR, and go to FAULT when TMR reaches TIMEOUT without ACK.
REQ-024 SHALL ignore ACK in every state except WAIT_ACK.
REQ-025 SHALL, in DONE: pulse FIM for 1 cycle, then return to IDLE.
REQ-026 SHALL, in FAULT: hold FALHA=1 and BUSY=1, ignore LOAD and REPOR, and exit only on RST.
REQ-027 SHALL drive BUSY=1 in SELECT, PULSE, WAIT_ACK and DONE, and BUSY=0 in IDLE.
REQ-028 SHALL meet this latency: LOAD sampled at edge n means the first EJx is high in the cycle after edge n+2; ACK sampled at edge m means the next EJx is high in the cycle after edge m+2.
REQ-029 SHALL, for TROCO=0: reach DONE with no EJ pulse and pulse FIM 2 cycles after LOAD.
REQ-030 SHALL never let a stock counter wrap below 0 and never let REM underflow.
REQ-031 SHALL never assert more than one EJ output in the same cycle.

Reset
REQ-032 SHALL, on RST=1 (any state, including mid-dispense): go to IDLE; set REM=0, TMR=0, and STK50, STK20, STK10 to STK_INIT; clear EJ50, EJ20, EJ10, BUSY, FIM, ERRO and FALHA.
REQ-033 SHALL derive VAZIO from the stock counters, so VAZIO=0 after reset when STK_INIT>0.
REQ-034 SHALL hold all outputs at their reset values while RST=1, and SHALL accept LOAD on the first edge after RST falls.

Verification
REQ-035 SHALL pass: full stock, LOAD with TROCO=10, ACK 3 cycles after each pulse -> EJ50, EJ50, then FIM; STK50=6.
REQ-036 SHALL pass: LOAD with TROCO=9 -> EJ50, EJ20, EJ20, then FIM; STK20=6 and STK10=8.
REQ-037 SHALL pass: STK20=0 via directed preload, LOAD with TROCO=7 -> EJ50, EJ10, EJ10, then FIM.
REQ-038 SHALL pass: STK10=0, STK20=1, LOAD with TROCO=3 -> EJ20, ACK, then FAULT with FALHA=1 and REM=1.
REQ-039 SHALL pass: ACK held at 0 after the first pulse -> FALHA=1 exactly TIMEOUT cycles after the pulse.
REQ-040 SHALL pass: RST asserted during WAIT_ACK -> IDLE immediately with BUSY=0 and stocks at 8; LOAD with TROCO=12 then pulses ERRO only.
